// File: rtl/duty_btn_pkg.sv
// Shared constants and types for the duty button conditioner.
// Repeat behaviour is compiled in only when BTN_AUTOREPEAT_EN is defined.
package duty_btn_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int REPEAT_DELAY_DEF    = 200;
   localparam int REPEAT_PERIOD_DEF   = 50;
   localparam int CNT_W_DEF           = 8;

   // Debounced level now and the value it takes on the coming edge.
   typedef struct packed {
      logic level;
      logic level_next;
   } btn_state_t;

   function automatic bit cnt_fits(input int w, input int deb, input int dly, input int per);
      int cap;
      cap = (32'sd1 <<< w) - 32'sd1;
      return (deb >= 32'sd2) && (deb <= cap) &&
             (dly >= 32'sd1) && (dly <= cap) &&
             (per >= 32'sd1) && (per <= cap);
   endfunction

endpackage

// File: rtl/duty_button_conditioner_if.sv
// Button-side and duty-step-side signals of the conditioner, grouped for benches
// and upstream integration.
interface duty_button_conditioner_if;

   logic increase_btn;
   logic decrease_btn;
   logic increase_duty_sync;
   logic decrease_duty_sync;
   logic inc_level;
   logic dec_level;

   modport master (
      output increase_btn,
      output decrease_btn,
      input  increase_duty_sync,
      input  decrease_duty_sync,
      input  inc_level,
      input  dec_level
   );

   modport slave (
      input  increase_btn,
      input  decrease_btn,
      output increase_duty_sync,
      output decrease_duty_sync,
      output inc_level,
      output dec_level
   );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser followed by a counting debouncer
// that flips the level only after DEBOUNCE_CYCLES consecutive mismatching samples.
module btn_debounce
   import duty_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       btn,
   output btn_state_t state_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s0_q;
   logic             s1_q;
   logic             level_q;
   logic             level_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Debounce next-state: any matching sample discards the partial count.
   always_comb begin
      level_d = level_q;
      cnt_d   = {CNT_W{1'b0}};
      if (s1_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = s1_q;
            cnt_d   = {CNT_W{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = {CNT_W{1'b0}};
      end
   end

   // Synchroniser, counter and level registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s0_q    <= 1'b0;
         s1_q    <= 1'b0;
         cnt_q   <= {CNT_W{1'b0}};
         level_q <= 1'b0;
      end else begin
         s0_q    <= btn;
         s1_q    <= s0_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign state_o.level      = level_q;
   assign state_o.level_next = level_d;

endmodule

// File: rtl/duty_button_conditioner.sv
// Two debounced button channels turned into mutually exclusive one-cycle duty-step
// pulses; BTN_AUTOREPEAT_EN adds timed repeat pulses while a single button is held.
module duty_button_conditioner
   import duty_btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic increase_btn,
   input  logic decrease_btn,
   output logic increase_duty_sync,
   output logic decrease_duty_sync,
   output logic inc_level,
   output logic dec_level
);

   localparam bit CFG_OK = cnt_fits(CNT_W, DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

   if (!CFG_OK) begin : g_bad_cfg
      $error("duty_button_conditioner: counter width or timing parameters out of range");
   end

   btn_state_t inc_st_s;
   btn_state_t dec_st_s;
   logic [1:0] lvl_s;
   logic [1:0] nxt_s;
   logic [1:0] press_s;
   logic [1:0] fire_s;
   logic [1:0] pulse_d;
   logic [1:0] pulse_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_inc (
      .clk     (clk),
      .reset   (reset),
      .btn     (increase_btn),
      .state_o (inc_st_s)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_dec (
      .clk     (clk),
      .reset   (reset),
      .btn     (decrease_btn),
      .state_o (dec_st_s)
   );

   // Index 0 is the increase channel, index 1 the decrease channel.
   assign lvl_s = {dec_st_s.level,      inc_st_s.level};
   assign nxt_s = {dec_st_s.level_next, inc_st_s.level_next};

   // A press counts only on a rising level while the other level is low on that edge.
   always_comb begin
      press_s    = 2'b00;
      press_s[0] = nxt_s[0] & ~lvl_s[0] & ~nxt_s[1];
      press_s[1] = nxt_s[1] & ~lvl_s[1] & ~nxt_s[0];
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [1:0][CNT_W-1:0] rep_cnt_q;
   logic [1:0][CNT_W-1:0] rep_cnt_d;
   logic [1:0]            armed_q;
   logic [1:0]            armed_d;
   logic [1:0]            first_q;
   logic [1:0]            first_d;

   // Repeat timing; any break in sole ownership disarms until the next fresh press.
   always_comb begin
      rep_cnt_d = {2{{CNT_W{1'b0}}}};
      armed_d   = armed_q;
      first_d   = first_q;
      fire_s    = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (press_s[i]) begin
            armed_d[i]   = 1'b1;
            first_d[i]   = 1'b1;
            rep_cnt_d[i] = {CNT_W{1'b0}};
         end else if (armed_q[i] & lvl_s[i] & nxt_s[i] & ~nxt_s[1-i]) begin
            if (rep_cnt_q[i] == (first_q[i] ? REP_DELAY_LAST : REP_PERIOD_LAST)) begin
               fire_s[i]    = 1'b1;
               first_d[i]   = 1'b0;
               rep_cnt_d[i] = {CNT_W{1'b0}};
            end else begin
               rep_cnt_d[i] = rep_cnt_q[i] + CNT_W'(1);
            end
         end else begin
            armed_d[i]   = 1'b0;
            first_d[i]   = 1'b0;
            rep_cnt_d[i] = {CNT_W{1'b0}};
         end
      end
   end

   // Repeat state registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rep_cnt_q <= {2{{CNT_W{1'b0}}}};
         armed_q   <= 2'b00;
         first_q   <= 2'b00;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         armed_q   <= armed_d;
         first_q   <= first_d;
      end
   end
`else
   // Single pulse per press: no repeat source.
   always_comb begin
      fire_s = 2'b00;
   end
`endif

   // Press and repeat sources share the one-cycle output register.
   always_comb begin
      pulse_d = press_s | fire_s;
   end

   // Output pulse register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pulse_q <= 2'b00;
      end else begin
         pulse_q <= pulse_d;
      end
   end

   assign increase_duty_sync = pulse_q[0];
   assign decrease_duty_sync = pulse_q[1];
   assign inc_level          = lvl_s[0];
   assign dec_level          = lvl_s[1];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Directed scenarios plus a random bounce soak, checked against a window-based
// reference model of the debounce, lockout and repeat rules.
module tb_duty_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 16;
   localparam int RP = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   duty_button_conditioner_if bus();

   duty_button_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .CNT_W           (8),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .increase_btn       (bus.increase_btn),
      .decrease_btn       (bus.decrease_btn),
      .increase_duty_sync (bus.increase_duty_sync),
      .decrease_duty_sync (bus.decrease_duty_sync),
      .inc_level          (bus.inc_level),
      .dec_level          (bus.dec_level)
   );

   int total = 0;
   int bad   = 0;

   // reference model state
   logic xi[$];
   logic xd[$];
   int   edge_n;
   logic m_il, m_dl, m_pi, m_pd;
   logic arm_i, arm_d;
   int   press_i, press_d;

   // observed statistics
   int   inc_cnt, dec_cnt, first_inc, first_dec, first_il;
   logic prev_pi, prev_pd;

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0b expected=%0b (edge %0d)", tag, obs, exp, edge_n);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic smp(input logic q[$], input int idx);
      if (idx >= 0 && idx < q.size()) return q[idx];
      return 1'b0;
   endfunction

   // The level flips once the last D synchronised samples all disagree with it;
   // the synchronised sample used at edge n is the raw sample from edge n-2.
   function automatic logic settles(input logic q[$], input logic lvl);
      int n;
      n = q.size();
      for (int j = 0; j < D; j++) begin
         if (smp(q, n - 3 - j) == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic repeat_due(input int since);
      return (since == RD) || (since > RD && ((since - RD) % RP) == 0);
   endfunction

   task automatic model_clear();
      xi.delete();
      xd.delete();
      edge_n = 0;
      m_il = 1'b0; m_dl = 1'b0; m_pi = 1'b0; m_pd = 1'b0;
      arm_i = 1'b0; arm_d = 1'b0; press_i = 0; press_d = 0;
      inc_cnt = 0; dec_cnt = 0; first_inc = -1; first_dec = -1; first_il = -1;
      prev_pi = 1'b0; prev_pd = 1'b0;
   endtask

   task automatic model_edge(input logic bi, input logic bd);
      logic ni, nd, pi, pd, ri, rdp;
      xi.push_back(bi);
      xd.push_back(bd);
      if (xi.size() > 32) begin
         void'(xi.pop_front());
         void'(xd.pop_front());
      end
      edge_n++;
      ni = settles(xi, m_il) ? ~m_il : m_il;
      nd = settles(xd, m_dl) ? ~m_dl : m_dl;
      pi = ni & ~m_il & ~nd;
      pd = nd & ~m_dl & ~ni;
      ri = 1'b0;
      rdp = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (pi) begin
         arm_i = 1'b1; press_i = edge_n;
      end else if (arm_i && ni && !nd) begin
         ri = repeat_due(edge_n - press_i);
      end else begin
         arm_i = 1'b0;
      end
      if (pd) begin
         arm_d = 1'b1; press_d = edge_n;
      end else if (arm_d && nd && !ni) begin
         rdp = repeat_due(edge_n - press_d);
      end else begin
         arm_d = 1'b0;
      end
`endif
      m_il = ni;
      m_dl = nd;
      m_pi = pi | ri;
      m_pd = pd | rdp;
   endtask

   task automatic step(input logic bi, input logic bd);
      bus.increase_btn = bi;
      bus.decrease_btn = bd;
      @(posedge clk);
      model_edge(bi, bd);
      #1;
      check("inc_level", bus.inc_level, m_il);
      check("dec_level", bus.dec_level, m_dl);
      check("inc_pulse", bus.increase_duty_sync, m_pi);
      check("dec_pulse", bus.decrease_duty_sync, m_pd);
      check("exclusive", bus.increase_duty_sync & bus.decrease_duty_sync, 1'b0);
      check("inc_width", bus.increase_duty_sync & prev_pi, 1'b0);
      check("dec_width", bus.decrease_duty_sync & prev_pd, 1'b0);
      prev_pi = bus.increase_duty_sync;
      prev_pd = bus.decrease_duty_sync;
      if (bus.increase_duty_sync) begin
         inc_cnt++;
         if (first_inc < 0) first_inc = edge_n;
      end
      if (bus.decrease_duty_sync) begin
         dec_cnt++;
         if (first_dec < 0) first_dec = edge_n;
      end
      if (bus.inc_level && first_il < 0) first_il = edge_n;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_inc_pulse"}, bus.increase_duty_sync, 1'b0);
      check({tag, "_dec_pulse"}, bus.decrease_duty_sync, 1'b0);
      check({tag, "_inc_level"}, bus.inc_level, 1'b0);
      check({tag, "_dec_level"}, bus.dec_level, 1'b0);
   endtask

   task automatic do_reset(input int cycles, input logic bi, input logic bd);
      bus.increase_btn = bi;
      bus.decrease_btn = bd;
      reset = 1'b1;
      #1;
      check_quiet("rst");
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1;
         check_quiet("rst_hold");
      end
      reset = 1'b0;
      model_clear();
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) step(1'b0, 1'b0);
   endtask

   initial begin
      int rise;
      int start;
      int run_i, run_d;
      logic vi, vd;
      bus.increase_btn = 1'b0;
      bus.decrease_btn = 1'b0;
      model_clear();

      // clean press sampled from edge 10
      do_reset(3, 1'b0, 1'b0);
      idle(9);
      for (int c = 0; c < 40; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("clean_level_edge", first_il, 10 + 1 + D);
      check_int("clean_pulse_edge", first_inc, 10 + 1 + D);
      check_int("clean_dec_count", dec_cnt, 0);

      // bounce then stable high
      do_reset(2, 1'b0, 1'b0);
      idle(5);
      for (int c = 0; c < 20; c++) step(((c / 2) % 2) == 0, 1'b0);
      rise = edge_n + 1;
      for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("bounce_pulse_edge", first_inc, rise + 1 + D);

      // short glitch alone
      do_reset(2, 1'b0, 1'b0);
      idle(4);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("glitch_inc_count", inc_cnt, 0);
      check_int("glitch_level_seen", first_il, -1);

      // simultaneous press
      do_reset(2, 1'b0, 1'b0);
      idle(3);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b1);
      check("simul_inc_level", bus.inc_level, 1'b1);
      check("simul_dec_level", bus.dec_level, 1'b1);
      idle(20);
      check_int("simul_inc_count", inc_cnt, 0);
      check_int("simul_dec_count", dec_cnt, 0);

      // dec held, inc joins, dec released while inc still held
      do_reset(2, 1'b0, 1'b0);
      idle(3);
      start = edge_n + 1;
      for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b1);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("lock_inc_count", inc_cnt, 0);
      check_int("lock_dec_edge", first_dec, start + 1 + D);

      // reset in the middle of debouncing a held button
      do_reset(2, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      do_reset(3, 1'b1, 1'b0);
      for (int c = 0; c < 30; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("rst_mid_pulse_edge", first_inc, 2 + D);

      // long hold
      do_reset(2, 1'b0, 1'b0);
      idle(2);
      for (int c = 0; c < 60; c++) step(1'b1, 1'b0);
      idle(20);
      check_int("hold_first_edge", first_inc, 3 + 1 + D);
`ifdef BTN_AUTOREPEAT_EN
      check_int("hold_inc_count", inc_cnt, 7);
`else
      check_int("hold_inc_count", inc_cnt, 1);
`endif

      // random bounce soak on both channels
      do_reset(2, 1'b0, 1'b0);
      vi = 1'b0; vd = 1'b0; run_i = 0; run_d = 0;
      for (int c = 0; c < 10000; c++) begin
         if (run_i == 0) begin
            vi = ~vi;
            run_i = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
         end
         if (run_d == 0) begin
            vd = ~vd;
            run_d = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
         end
         step(vi, vd);
         run_i--;
         run_d--;
      end
      idle(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/duty_button_conditioner.md
Name: duty_button_conditioner

Overview:
Upstream stage of the PWM duty controller. Takes two raw, asynchronous push-button inputs (increase, decrease). Synchronises and debounces each one, then emits clean single-cycle pulses on increase_duty_sync / decrease_duty_sync, which feed the PWM block's duty-step inputs directly. The two channels are mutually exclusive: the PWM block never sees both pulses in the same cycle.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive mismatching samples required before the debounced level flips (min 2)
CNT_W, 8, debounce/repeat counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
REPEAT_DELAY, 200, cycles from the press pulse to the first auto-repeat pulse (BTN_AUTOREPEAT_EN only)
REPEAT_PERIOD, 50, cycles between subsequent auto-repeat pulses (BTN_AUTOREPEAT_EN only)

Ports:
clk  input  1  system clock; all state on the rising edge
reset  input  1  asynchronous, active-high reset
increase_btn  input  1  raw increase button, asynchronous, may bounce
decrease_btn  input  1  raw decrease button, asynchronous, may bounce
increase_duty_sync  output  1  registered one-cycle increase pulse
decrease_duty_sync  output  1  registered one-cycle decrease pulse
inc_level  output  1  debounced increase level (status/debug)
dec_level  output  1  debounced decrease level (status/debug)

Behaviour:
- Reset: all flops clear, including sync stages, counters, levels and pulses. All outputs are 0 while reset is high and in the first cycle after release.
- Synchroniser: two-flop chain per channel (s0 <= btn, s1 <= s0). Only s1 is used downstream.
- Debounce, per channel:
  - If s1 != level: cnt increments.
  - If s1 != level and cnt == DEBOUNCE_CYCLES-1: level <= s1 and cnt <= 0 on that edge.
  - If s1 == level: cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES samples is fully discarded.
- Latency: if the button is sampled high at edge k, then s1 goes high at k+1, level rises at edge k+1+DEBOUNCE_CYCLES, and the pulse is high for exactly the cycle following that edge.
- Pulse generation (registered): for inc, pulse <= level_next_inc & ~level_inc & ~level_next_dec. Dec is symmetric.
- Conflict lockout:
  - If the other channel's debounced level is, or becomes, high on the same edge, no pulse is emitted.
  - Simultaneous press: both levels rise, neither pulse fires.
  - Pressing inc while dec is held: no inc pulse, and releasing dec does not retroactively fire inc.
- Release (level falling) never produces a pulse.
- The two outputs are never high in the same cycle, under any input sequence.
- Reset mid-operation clears everything. A button still held when reset releases is re-synchronised and debounced, and then pulses once as a fresh press.

Optional Feature:
Macro BTN_AUTOREPEAT_EN.
- Defined:
  - While a channel's level stays high and the other's stays low, a per-channel repeat counter runs.
  - The first extra pulse comes REPEAT_DELAY cycles after the press pulse; further pulses follow every REPEAT_PERIOD cycles.
  - Level falling, or the other level rising, clears the repeat counter and stops repeats immediately.
  - Repeat pulses obey the same one-cycle width and mutual-exclusion rules.
- Undefined: exactly one pulse per debounced press, and no repeat counter is synthesised.

Decomposition:
- Shared package duty_btn_pkg: default constants DEBOUNCE_CYCLES_DEF, REPEAT_DELAY_DEF, REPEAT_PERIOD_DEF, CNT_W_DEF.
- Sub-module btn_debounce (sync chain, debounce counter, level), instantiated once per channel.
- The top level holds pulse generation, lockout and the optional repeat logic.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8):
- Clean press: increase_btn high from edge 10, held for 40 cycles -> inc_level rises at edge 15; increase_duty_sync high for one cycle after edge 15 only; decrease_duty_sync stays 0.
- Bounce: increase_btn toggles every 2 cycles for 20 cycles, then stays high -> no pulse during the bounce; exactly one pulse 5 edges after the last rise; glitch of 3 cycles alone -> no pulse, inc_level stays 0.
- Conflict: both buttons rise on the same edge -> neither pulse fires, both levels high; dec pressed, then inc pressed 10 cycles later -> one dec pulse only.
- Reset mid-debounce: reset asserted 2 cycles after inc rises, held for 3 cycles while the button stays high -> all outputs 0 during reset; one pulse 6 edges after reset release.
- Auto-repeat (macro defined): inc held 60 cycles -> pulses at press P, P+16, P+24, P+32 … until release; macro undefined -> pulse at P only.
- Random bounce soak on both inputs for 10k cycles -> the outputs are never high together, and every pulse is exactly one cycle wide.
